// File: rtl/pll_nx_model.sv
// Behavioural PLL model: multiplies ref_clk by MULT, measuring its period on an internal 10 GHz sample clock.
// Optional macro PLL_NX_OUT_GATE_EN holds out_clk low while unlocked (gated at ref_clk rises).
`timescale 100ps/10ps

module pll_nx_model #(
    parameter int unsigned MULT        = 8,
    parameter int unsigned PERIOD_W    = 12,
    parameter int unsigned LOCK_CYCLES = 3,
    parameter int unsigned TOL         = 2
) (
    input  logic                ref_clk,
    input  logic                RST_n,
    output logic                out_clk,
    output logic                locked,
    output logic [PERIOD_W-1:0] ref_period,
    output logic                lock_lost
);
    localparam int unsigned SH    = $clog2(MULT);
    localparam int unsigned IDX_W = (SH > 0) ? SH : 1;
    localparam int unsigned GC_W  = 4;
    localparam logic [PERIOD_W-1:0] SAT        = '1;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * MULT);
    localparam logic [PERIOD_W-1:0] TOL_W      = PERIOD_W'(TOL);
    localparam logic [GC_W-1:0]     LOCK_N     = GC_W'(LOCK_CYCLES);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(MULT - 1);

    if (MULT != 2 && MULT != 4 && MULT != 8 && MULT != 16 && MULT != 32) begin : g_bad_mult
        $fatal(1, "pll_nx_model: illegal MULT %0d", MULT);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 15) begin : g_bad_lock
        $fatal(1, "pll_nx_model: illegal LOCK_CYCLES %0d", LOCK_CYCLES);
    end

    typedef enum logic [1:0] {ST_RST, ST_ACQ, ST_LOCK} state_t;

    logic                smpl_clk;
    state_t              state;
    logic [GC_W-1:0]     good_cnt;
    logic [1:0]          seen;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] sub;
    logic [IDX_W-1:0]    idx;
    logic                run;
    logic                ref_d;
    bit                  warned;

    // 10 GHz sample clock, first rise half a tick after time 0
    always begin
        smpl_clk = 1'b0;
        #0.5;
        smpl_clk = 1'b1;
        #0.5;
    end

    logic [PERIOD_W-1:0] diff_c, cnt_inc_c, full_c, half_c, half_new_c, sub_inc_c;
    logic                in_tol_c, start_c;
    state_t              state_ref_n, state_smp_n;
    logic [GC_W-1:0]     good_ref_n, good_smp_n;
    logic                lost_ref_n, lost_smp_n;
    logic                out_smp_n, run_smp_n;
    logic [PERIOD_W-1:0] sub_smp_n;
    logic [IDX_W-1:0]    idx_smp_n;

    // Next state for both event kinds; the register block picks one per trigger
    always_comb begin
        diff_c     = (cnt > ref_period) ? cnt - ref_period : ref_period - cnt;
        in_tol_c   = (seen == 2'd2) && (diff_c <= TOL_W) && (cnt != SAT) && (cnt >= MIN_PERIOD);
        cnt_inc_c  = (cnt == SAT) ? cnt : cnt + PERIOD_W'(1);
        full_c     = ref_period >> SH;
        half_c     = ref_period >> (SH + 1);
        half_new_c = cnt >> (SH + 1);
        sub_inc_c  = sub + PERIOD_W'(1);

        state_ref_n = state;
        good_ref_n  = good_cnt;
        lost_ref_n  = 1'b0;
        case (state)
            ST_RST: state_ref_n = ST_ACQ;
            ST_ACQ: begin
                if (in_tol_c) begin
                    good_ref_n = good_cnt + GC_W'(1);
                    if (good_ref_n >= LOCK_N) state_ref_n = ST_LOCK;
                end else begin
                    good_ref_n = '0;
                end
            end
            ST_LOCK: begin
                if (!in_tol_c) begin
                    state_ref_n = ST_ACQ;
                    good_ref_n  = '0;
                    lost_ref_n  = 1'b1;
                end
            end
            default: state_ref_n = ST_RST;
        endcase

`ifdef PLL_NX_OUT_GATE_EN
        start_c = (seen != 2'd0) && (half_new_c != '0) && (state_ref_n == ST_LOCK);
`else
        start_c = (seen != 2'd0) && (half_new_c != '0);
`endif

        // A stopped reference is detected on the tick that saturates the counter
        state_smp_n = state;
        good_smp_n  = good_cnt;
        lost_smp_n  = 1'b0;
        if (state == ST_LOCK && cnt != SAT && cnt_inc_c == SAT) begin
            state_smp_n = ST_ACQ;
            good_smp_n  = '0;
            lost_smp_n  = 1'b1;
        end

        out_smp_n = out_clk;
        run_smp_n = run;
        sub_smp_n = sub;
        idx_smp_n = idx;
        if (run) begin
            sub_smp_n = sub_inc_c;
            if (sub_inc_c == half_c) out_smp_n = 1'b0;
            if (sub_inc_c == full_c) begin
                if (idx < LAST_IDX) begin
                    out_smp_n = 1'b1;
                    sub_smp_n = '0;
                    idx_smp_n = idx + IDX_W'(1);
                end else begin
                    run_smp_n = 1'b0;
                end
            end
        end
    end

    // ref_d tells a ref_clk rise apart from a sample tick; a coincident pair resolves to the ref edge
    always_ff @(posedge ref_clk or posedge smpl_clk or negedge RST_n) begin
        if (!RST_n) begin
            ref_d      <= ref_clk;
            state      <= ST_RST;
            good_cnt   <= '0;
            seen       <= '0;
            cnt        <= '0;
            ref_period <= '0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            out_clk    <= 1'b0;
            run        <= 1'b0;
            sub        <= '0;
            idx        <= '0;
        end else if (ref_clk && !ref_d) begin
            ref_d      <= 1'b1;
            state      <= state_ref_n;
            good_cnt   <= good_ref_n;
            locked     <= (state_ref_n == ST_LOCK);
            lock_lost  <= lost_ref_n;
            ref_period <= cnt;
            cnt        <= '0;
            seen       <= (seen == 2'd2) ? seen : seen + 2'd1;
            out_clk    <= start_c;
            run        <= start_c;
            sub        <= '0;
            idx        <= '0;
        end else begin
            ref_d      <= ref_clk;
            state      <= state_smp_n;
            good_cnt   <= good_smp_n;
            locked     <= (state_smp_n == ST_LOCK);
            lock_lost  <= lost_smp_n;
            cnt        <= cnt_inc_c;
            out_clk    <= out_smp_n;
            run        <= run_smp_n;
            sub        <= sub_smp_n;
            idx        <= idx_smp_n;
        end
    end

    // One-shot warning when lock is reached with a coarse sample resolution per output cycle
    always @(posedge locked) begin
        if (!warned && 32'(ref_period) < 16 * MULT) begin
            $display("pll_nx_model: warning, locked with ref_period %0d below %0d ticks",
                     ref_period, 16 * MULT);
            warned <= 1'b1;
        end
    end

endmodule
